control: RTL and testbench

//  Sequencing controller for the counting datapath: once `counting` is

---
 rtl/control_pkg.sv | 18 +
 rtl/control_counter.sv | 40 ++++
 rtl/control.sv | 79 +++++++
 tb/tb_control.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared types and defaults for the interval-timing controller.
// Imported by the counter and the top-level FSM.
package control_pkg;

    localparam int unsigned TERM_COUNT_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Counter width able to hold 0..term
    function automatic int unsigned cnt_width(input int unsigned term);
        return (term < 1) ? 1 : $clog2(term + 1);
    endfunction

endpackage

// File: rtl/control_counter.sv
// Interval counter: clears to zero, advances when enabled,
// and flags the last count of the interval (TERM_COUNT-1).
module control_counter
    import control_pkg::*;
#(
    parameter int unsigned TERM_COUNT = TERM_COUNT_DEF,
    localparam int unsigned CNT_WIDTH = cnt_width(TERM_COUNT)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic terminal_o
);

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TERM_COUNT - 1);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign terminal_o = (cnt_q == LAST);

endmodule

// File: rtl/control.sv
// Sequencing controller: times TERM_COUNT sampled-high cycles of
// `counting`, then emits a one-cycle registered `ready` pulse.
module control
    import control_pkg::*;
#(
    parameter int unsigned TERM_COUNT = TERM_COUNT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic counting,
    output logic ready
);

    state_e state_q;
    state_e state_d;
    logic   ready_q;
    logic   ready_d;
    logic   cnt_clear;
    logic   cnt_enable;
    logic   cnt_terminal;

    control_counter #(
        .TERM_COUNT (TERM_COUNT)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (cnt_clear),
        .enable_i   (cnt_enable),
        .terminal_o (cnt_terminal)
    );

    always_comb begin
        state_d    = state_q;
        ready_d    = 1'b0;
        cnt_clear  = 1'b0;
        cnt_enable = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clear = 1'b1;
                if (counting) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // counting low pauses the interval; cnt is held
                if (counting) begin
                    if (cnt_terminal) begin
                        cnt_clear = 1'b1;
                        ready_d   = 1'b1;
                        state_d   = DONE;
                    end else begin
                        cnt_enable = 1'b1;
                    end
                end
            end
            DONE: begin
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                cnt_clear = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule

// File: tb/tb_control.sv
// Self-checking bench for control: two instances (TERM_COUNT 8 and 1)
// share one counting input and are checked against a cycle model.
module tb_control;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic counting = 1'b0;
    logic ready8;
    logic ready1;

    int vectors = 0;
    int errors  = 0;

    control #(.TERM_COUNT(8)) dut8 (
        .clk      (clk),
        .rst      (rst),
        .counting (counting),
        .ready    (ready8)
    );

    control #(.TERM_COUNT(1)) dut1 (
        .clk      (clk),
        .rst      (rst),
        .counting (counting),
        .ready    (ready1)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int cnt;
        bit rdy;
    } mstate_t;

    mstate_t m8;
    mstate_t m1;
    bit      expq[$];

    function automatic mstate_t mreset();
        mstate_t n;
        n.st  = 0;
        n.cnt = 0;
        n.rdy = 1'b0;
        return n;
    endfunction

    function automatic mstate_t mstep(mstate_t s, bit c, int term);
        mstate_t n = s;
        n.rdy = 1'b0;
        case (s.st)
            0: if (c) begin
                n.st  = 1;
                n.cnt = 0;
            end
            1: if (c) begin
                if (s.cnt == term - 1) begin
                    n.cnt = 0;
                    n.rdy = 1'b1;
                    n.st  = 2;
                end else begin
                    n.cnt = s.cnt + 1;
                end
            end
            default: n.st = 0;
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive, step model, push expectations, sample at edge+1
    task automatic tick(input bit c);
        bit e8;
        bit e1;
        counting = c;
        @(posedge clk);
        if (rst) begin
            m8 = mreset();
            m1 = mreset();
        end else begin
            m8 = mstep(m8, c, 8);
            m1 = mstep(m1, c, 1);
        end
        expq.push_back(m8.rdy);
        expq.push_back(m1.rdy);
        #1;
        e8 = expq.pop_front();
        e1 = expq.pop_front();
        chk("ready8_sb", ready8, e8);
        chk("ready1_sb", ready1, e1);
    endtask

    // Asynchronous reset pulse placed mid-cycle
    task automatic do_reset();
        #3 rst = 1'b1;
        #1;
        m8 = mreset();
        m1 = mreset();
        chk("ready8_async_rst", ready8, 1'b0);
        chk("ready1_async_rst", ready1, 1'b0);
        tick(1'b0);
        #3 rst = 1'b0;
        counting = 1'b0;
    endtask

    typedef struct {
        string name;
        int    pause_at;
        int    pause_len;
        int    exp_rise;
    } vec_t;

    vec_t vecs[4];

    task automatic run_vec(input vec_t v);
        int  rise;
        bit  c;
        rise = -1;
        for (int t = 0; t < 40; t++) begin
            c = !((t >= v.pause_at) && (t < v.pause_at + v.pause_len));
            tick(c);
            if (rise >= 0) begin
                chk({v.name, "_width"}, ready8, 1'b0);
                break;
            end
            if (ready8 === 1'b1) rise = t;
        end
        vectors++;
        if (rise != v.exp_rise) begin
            errors++;
            $display("FAIL %s_rise: got edge %0d expected edge %0d", v.name, rise, v.exp_rise);
        end
    endtask

    initial begin
        int r8[$];
        int r1[$];

        vecs[0] = '{"nopause",   -1, 0, 8};
        vecs[1] = '{"pause3",     5, 3, 11};
        vecs[2] = '{"pause1",     1, 1, 9};
        vecs[3] = '{"pauseterm",  8, 2, 10};

        m8 = mreset();
        m1 = mreset();

        // idle after reset
        @(posedge clk);
        #1;
        do_reset();
        for (int i = 0; i < 10; i++) tick(1'b0);
        chk("idle_ready8", ready8, 1'b0);

        // interval timing with and without pauses
        foreach (vecs[i]) begin
            run_vec(vecs[i]);
            do_reset();
        end

        // reset mid-COUNT after 5 counts, then full interval
        for (int i = 0; i < 6; i++) tick(1'b1);
        do_reset();
        run_vec(vecs[0]);
        do_reset();

        // reset while ready is high
        for (int i = 0; i < 9; i++) tick(1'b1);
        chk("ready_before_rst", ready8, 1'b1);
        do_reset();

        // reset coincident with the terminal edge: no pulse
        for (int i = 0; i < 8; i++) tick(1'b1);
        #3 rst = 1'b1;
        tick(1'b1);
        chk("rst_wins_terminal", ready8, 1'b0);
        #3 rst = 1'b0;
        tick(1'b0);
        chk("rst_wins_after", ready8, 1'b0);
        do_reset();

        // continuous request: period 10 for 8, period 3 for 1
        for (int t = 0; t < 30; t++) begin
            tick(1'b1);
            if (ready8 === 1'b1) r8.push_back(t);
            if (ready1 === 1'b1) r1.push_back(t);
        end
        vectors++;
        if (r8.size() != 3 || r8[0] != 8 || r8[1] != 18 || r8[2] != 28) begin
            errors++;
            $display("FAIL period8: got %p expected '{8,18,28}", r8);
        end
        vectors++;
        if (r1.size() != 10 || r1[0] != 1 || r1[1] != 4 || r1[9] != 28) begin
            errors++;
            $display("FAIL period1: got %p expected 1,4,..,28 (10 pulses)", r1);
        end

        do_reset();
        tick(1'b0);
        chk("final_idle", ready8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
